// File: rtl/load_use_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and branch-operand hazards, memory wait holds.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module load_use_hazard_unit
`ifdef HAZARD_PERF_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IDEX_MemRead,
   input  logic             IDEX_RegWrite,
   input  logic [4:0]       IDEX_DstAddr,
   input  logic [4:0]       IFID_RsAddr,
   input  logic [4:0]       IFID_RtAddr,
   input  logic             IFID_UsesRt,
   input  logic             IFID_IsBranch,
   input  logic             Branch_taken,
   input  logic             dmem_stall,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic             pipe_hold
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
`endif
);

   logic [1:0] r_cnt;
   logic       w_match_rs;
   logic       w_match_rt;
   logic       w_match;
   logic [1:0] w_need;

   assign w_match_rs = (IDEX_DstAddr != 5'd0) && (IDEX_DstAddr == IFID_RsAddr);
   assign w_match_rt = (IDEX_DstAddr != 5'd0) && IFID_UsesRt && (IDEX_DstAddr == IFID_RtAddr);
   assign w_match    = w_match_rs || w_match_rt;

   // A load feeding an ID-stage branch needs its value one cycle later than a plain load-use.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_need = 2'd0;
      if (IDEX_MemRead && w_match && IFID_IsBranch)
         w_need = 2'd2;
      else if (IDEX_MemRead && w_match)
         w_need = 2'd1;
      else if (IDEX_RegWrite && w_match && IFID_IsBranch)
         w_need = 2'd1;
   end

   always_comb begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
      pipe_hold   = 1'b0;
      if (!rst_n) begin
         IDEX_Bubble = 1'b1;
         IFID_Flush  = 1'b1;
      end else if (dmem_stall) begin
         pipe_hold = 1'b1;
      end else if ((r_cnt != 2'd0) || (w_need != 2'd0)) begin
         IDEX_Bubble = 1'b1;
      end else begin
         PCWrite    = 1'b1;
         IFIDWrite  = 1'b1;
         IFID_Flush = Branch_taken;
      end
   end

   // Memory wait freezes the bubble count so remaining bubbles resume afterwards.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n)
         r_cnt <= 2'd0;
      else if (dmem_stall)
         r_cnt <= r_cnt;
      else if (r_cnt != 2'd0)
         r_cnt <= r_cnt - 2'd1;
      else if (w_need != 2'd0)
         r_cnt <= w_need - 2'd1;
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!PCWrite)
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (IFID_Flush)
            r_flush_count <= r_flush_count + CNT_W'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboard bench for load_use_hazard_unit: driver pushes expected outputs, negedge monitor compares.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_load_use_hazard_unit;

   localparam logic [4:0] RUN  = 5'b11000; // {PCWrite,IFIDWrite,Bubble,Flush,hold}
   localparam logic [4:0] RUNF = 5'b11010;
   localparam logic [4:0] STL  = 5'b00100;
   localparam logic [4:0] MEM  = 5'b00001;
   localparam logic [4:0] RST  = 5'b00110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       IDEX_MemRead = 1'b0;
   logic       IDEX_RegWrite = 1'b0;
   logic [4:0] IDEX_DstAddr = 5'd0;
   logic [4:0] IFID_RsAddr = 5'd0;
   logic [4:0] IFID_RtAddr = 5'd0;
   logic       IFID_UsesRt = 1'b0;
   logic       IFID_IsBranch = 1'b0;
   logic       Branch_taken = 1'b0;
   logic       dmem_stall = 1'b0;
   logic       PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, pipe_hold;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   load_use_hazard_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .IDEX_MemRead (IDEX_MemRead),
      .IDEX_RegWrite(IDEX_RegWrite),
      .IDEX_DstAddr (IDEX_DstAddr),
      .IFID_RsAddr  (IFID_RsAddr),
      .IFID_RtAddr  (IFID_RtAddr),
      .IFID_UsesRt  (IFID_UsesRt),
      .IFID_IsBranch(IFID_IsBranch),
      .Branch_taken (Branch_taken),
      .dmem_stall   (dmem_stall),
      .PCWrite      (PCWrite),
      .IFIDWrite    (IFIDWrite),
      .IDEX_Bubble  (IDEX_Bubble),
      .IFID_Flush   (IFID_Flush),
      .pipe_hold    (pipe_hold)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  out;
      bit          chk_cnt;
      int unsigned stl;
      int unsigned fl;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so sample mid-cycle after the driver has settled inputs.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, {27'd0, PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, pipe_hold}, {27'd0, e.out});
`ifdef HAZARD_PERF_EN
         if (e.chk_cnt) begin
            check({e.name, ".stall_cycles"}, stall_cycles, e.stl);
            check({e.name, ".flush_count"}, flush_count, e.fl);
         end
`endif
      end
   end

   task automatic step(input logic rst, input logic mr, input logic rw, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic br,
                       input logic tk, input logic dm, input logic [4:0] exp, input string nm,
                       input bit cc = 1'b0, input int unsigned es = 0, input int unsigned ef = 0);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst; IDEX_MemRead = mr; IDEX_RegWrite = rw; IDEX_DstAddr = dst;
      IFID_RsAddr = rs; IFID_RtAddr = rt; IFID_UsesRt = ur; IFID_IsBranch = br;
      Branch_taken = tk; dmem_stall = dm;
      e.out = exp; e.chk_cnt = cc; e.stl = es; e.fl = ef; e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      //   rst mr rw dst  rs  rt  ur br tk dm  expected
      step(0, 0, 0, 0,   0,  0,  0, 0, 0, 0, RST,  "reset");
      step(0, 1, 1, 8,   8,  0,  0, 0, 1, 0, RST,  "reset_with_hazard");
      step(1, 0, 0, 0,   0,  0,  0, 0, 0, 0, RUN,  "first_run", 1'b1, 0, 0);
      step(1, 1, 1, 8,   8,  0,  0, 0, 0, 0, STL,  "load_use_stall");
      step(1, 0, 0, 0,   8,  0,  0, 0, 0, 0, RUN,  "load_use_resume");
      step(1, 1, 1, 9,   0,  9,  1, 1, 1, 0, STL,  "load_branch_stall1");
      step(1, 1, 1, 9,   0,  9,  1, 1, 1, 0, STL,  "load_branch_hold");
      step(1, 0, 0, 0,   0,  9,  1, 1, 1, 0, RUNF, "load_branch_flush");
      step(1, 0, 0, 0,   0,  0,  0, 0, 0, 0, RUN,  "after_flush");
      step(1, 1, 1, 0,   0,  0,  0, 0, 0, 0, RUN,  "reg_zero");
      step(1, 1, 1, 5,   0,  5,  0, 0, 0, 0, RUN,  "rt_unused");
      step(1, 0, 1, 3,   3,  0,  0, 1, 0, 0, STL,  "alu_branch_stall");
      step(1, 0, 0, 0,   3,  0,  0, 1, 0, 0, RUN,  "alu_branch_resume");
      step(1, 0, 1, 3,   3,  0,  0, 0, 0, 0, RUN,  "alu_nobranch", 1'b1, 4, 1);
      step(1, 1, 1, 9,   0,  9,  1, 1, 0, 0, STL,  "memwait_stall1");
      step(1, 1, 1, 9,   0,  9,  1, 1, 1, 1, MEM,  "memwait_dmem1");
      step(1, 1, 1, 9,   0,  9,  1, 1, 1, 1, MEM,  "memwait_dmem2");
      step(1, 1, 1, 9,   0,  9,  1, 1, 1, 1, MEM,  "memwait_dmem3");
      step(1, 1, 1, 9,   0,  9,  1, 1, 0, 0, STL,  "memwait_hold");
      step(1, 0, 0, 0,   0,  0,  0, 0, 0, 0, RUN,  "memwait_resume", 1'b1, 9, 1);
      step(1, 1, 1, 9,   0,  9,  1, 1, 0, 0, STL,  "midhold_stall1");
      step(0, 1, 1, 9,   0,  9,  1, 1, 0, 0, RST,  "midhold_reset");
      step(1, 0, 0, 0,   0,  0,  0, 0, 0, 0, RUN,  "midhold_after", 1'b1, 0, 0);
      step(1, 0, 0, 0,   0,  0,  0, 1, 1, 1, MEM,  "taken_under_dmem");
      step(1, 0, 0, 0,   0,  0,  0, 1, 1, 0, RUNF, "taken_after_dmem");
      step(1, 0, 0, 0,   0,  0,  0, 0, 0, 0, RUN,  "final_idle", 1'b1, 1, 1);

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_use_hazard_unit.md
# load_use_hazard_unit

- Stall and flush controller for the 5-stage pipeline.
- Looks at the instruction sitting in the ID/EX register and the instruction being decoded in IF/ID.
- Detects read-after-write hazards that forwarding cannot cover and inserts the required number of bubbles.
- Drives the write enables of the PC and IF/ID registers, the bubble control for the ID/EX register, the IF/ID flush, and a global hold for data-memory wait states.

## Interface

Parameters:
- `CNT_W`, 32: width of the performance counters (only present with `HAZARD_PERF_EN`).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `IDEX_MemRead` input 1: the instruction in EX is a load.
- `IDEX_RegWrite` input 1: the instruction in EX writes a register.
- `IDEX_DstAddr` input 5: destination register of the EX instruction, after RegDst selection.
- `IFID_RsAddr` input 5: rs field of the instruction in ID.
- `IFID_RtAddr` input 5: rt field of the instruction in ID.
- `IFID_UsesRt` input 1: the ID instruction reads rt as a source.
- `IFID_IsBranch` input 1: the ID instruction is a branch that compares its operands in ID.
- `Branch_taken` input 1: the branch in ID resolved as taken.
- `dmem_stall` input 1: data memory is not ready; freeze the whole pipeline.
- `PCWrite` output 1: PC update enable.
- `IFIDWrite` output 1: IF/ID register load enable.
- `IDEX_Bubble` output 1: forces all ID/EX control inputs (RegWrite, Mem2Reg, MemRead, MemWrite, ALUOp, RegDst, ALU_Src) to 0.
- `IFID_Flush` output 1: clears IF/ID to a NOP on the next edge.
- `pipe_hold` output 1: hold ID/EX, EX/MEM and MEM/WB.
- `stall_cycles` output CNT_W: performance counter (macro only).
- `flush_count` output CNT_W: performance counter (macro only).

## Operation

Hazard match:
- `match_rs` = (IDEX_DstAddr != 0) && (IDEX_DstAddr == IFID_RsAddr).
- `match_rt` = (IDEX_DstAddr != 0) && IFID_UsesRt && (IDEX_DstAddr == IFID_RtAddr).
- `m` = match_rs || match_rt.

Bubbles required (`need`), first matching rule wins:
- IDEX_MemRead && m && IFID_IsBranch → 2.
- IDEX_MemRead && m → 1.
- IDEX_RegWrite && !IDEX_MemRead && m && IFID_IsBranch → 1.
- Otherwise → 0.

State is a 2-bit down-counter `cnt`:
- RUN when cnt == 0.
- HOLD when cnt > 0.

Output priority, highest first:
1. `!rst_n`: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=1, pipe_hold=0.
2. `dmem_stall`: PCWrite=0, IFIDWrite=0, IDEX_Bubble=0, IFID_Flush=0, pipe_hold=1. `cnt` holds; no detection, no flush.
3. HOLD: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0. `cnt` ← cnt−1. Detection is disabled.
4. RUN with need > 0: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0. `cnt` ← need−1.
5. RUN with need == 0:
   - PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, pipe_hold=0.
   - IFID_Flush = Branch_taken.

Rules:
- Outputs not listed in a case are 0.
- A stall always suppresses `Branch_taken`. The branch is re-evaluated once RUN resumes with ready operands.
- `cnt` never exceeds 1.

Reset:
- `rst_n` low at a rising edge clears `cnt` to 0 (RUN) and clears both counters.
- Reset in the middle of a HOLD abandons the remaining bubbles.

## Timing

- Detection is combinational, with zero latency: stall outputs are asserted in the same cycle the hazard is visible on the inputs.
- A load-use hazard gives exactly 1 stall cycle.
- A load feeding a branch gives 2 consecutive stall cycles: the detection cycle plus one HOLD cycle.
- An ALU result feeding a branch gives 1 stall cycle.
- `dmem_stall` cycles are inserted without consuming HOLD count. Bubbles resume where they left off after `dmem_stall` drops.
- The first cycle after `rst_n` returns high is RUN. Outputs follow rule 5 when there is no hazard.
- `IFID_Flush` is a single-cycle pulse per taken branch. If `Branch_taken` stays high across a stall, the flush fires in the first RUN cycle.

## Configuration

`HAZARD_PERF_EN`:
- Defined:
  - `stall_cycles` increments on every cycle where PCWrite=0 and rst_n=1 (hazard stalls and dmem_stall cycles).
  - `flush_count` increments on every cycle where IFID_Flush=1 and rst_n=1.
  - Both wrap at 2^CNT_W, with no saturation.
- Not defined:
  - Both ports are absent.
  - No counter logic is built.

## Test plan

- **Load-use:** IDEX_MemRead=1, IDEX_DstAddr=8, IFID_RsAddr=8, IsBranch=0 → exactly 1 cycle of PCWrite=0 and Bubble=1. Next cycle (inputs show the bubble, MemRead=0) → PCWrite=1.
- **Load feeding a branch:** IDEX_MemRead=1, DstAddr=9, IFID_RtAddr=9, UsesRt=1, IsBranch=1, Branch_taken=1 → 2 stall cycles with IFID_Flush=0. Third cycle: flush=1, PCWrite=1.
- **Register zero:** IDEX_MemRead=1, DstAddr=0, RsAddr=0 → no stall. Also: DstAddr=5, RtAddr=5, UsesRt=0 → no stall.
- **Memory wait during HOLD:** dmem_stall=1 for 3 cycles during HOLD → pipe_hold=1, Bubble=0 for 3 cycles. Then 1 remaining bubble, then RUN. `stall_cycles` +5 for the whole sequence.
- **Reset mid-HOLD:** rst_n=0 for 1 edge during HOLD → cnt=0, counters=0. Next cycle with no hazard → PCWrite=1.
- **ALU result feeding a branch:** IDEX_RegWrite=1, MemRead=0, DstAddr=3, RsAddr=3, IsBranch=1 → 1 stall cycle. Same case with IsBranch=0 → no stall.
